tdm_demux_4: RTL and testbench
==============================

# tdm_demux_4

Four-lane time-division demultiplexer: the receive end of a serial link on which a 4:1 lane multiplexer sends slots d0, d1, d2, d3 in round-robin order over one shared data bus.
- Locks to a start-of-frame marker and counts slots.
- Buffers a partial frame, then presents all four lanes together, registered, with a one-cycle frame strobe.
- Sits between the shared-bus receiver and lane-parallel consumer logic.

## Interface
Parameters:
- W, 4, lane/bus data width in bits (W >= 1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- din  in  W  serial slot data
- din_valid  in  1  beat present on din this cycle
- din_sof  in  1  beat is slot 0 of a frame; ignored when din_valid=0
- din_par  in  1  even parity over din; present only with TDM_DEMUX_PARITY_EN
- y0, y1, y2, y3  out  W  lane outputs, registered, updated only on frame commit
- frame_valid  out  1  one-cycle pulse: y0..y3 hold a new complete frame
- sync_err  out  1  one-cycle pulse: framing violation detected
- locked  out  1  1 while in LOCKED state
- par_err  out  1  one-cycle pulse: frame dropped for parity; present only with TDM_DEMUX_PARITY_EN

## Operation
Reset (rst_n=0 at a clk edge) sets:
- state=HUNT, slot=0, shadow registers=0
- y0..y3=0, frame_valid=0, sync_err=0, locked=0, par_err=0
- Reset mid-frame discards the partial frame, and y0..y3 are cleared.

Terminology:
- A beat is a cycle with din_valid=1.
- Cycles with din_valid=0 change nothing except clearing the pulses.
- Any number of idle cycles may appear between beats.

State HUNT:
- Beats with din_sof=0 are dropped silently, with no sync_err.
- A beat with din_sof=1 is stored in shadow0; slot becomes 1 and state becomes LOCKED.

State LOCKED, slot counter 2 bits, values 0..3:
- slot=0, din_sof=1: store to shadow0; slot becomes 1.
- slot=0, din_sof=0: sync_err pulse. Drop the beat; go to HUNT.
- slot=1 or 2, din_sof=0: store to shadow[slot]; slot increments.
- slot=3, din_sof=0: commit. y0/y1/y2 are loaded from shadow0..2 and y3 from din; frame_valid pulses; slot wraps to 0 and the state stays LOCKED.
- slot=1..3, din_sof=1: sync_err pulse. The partial frame is discarded with no commit and y is unchanged. The beat is stored as the new slot 0 and slot becomes 1 (resync without going through HUNT).

Other rules:
- locked mirrors state.
- y0..y3 hold their last committed frame indefinitely.
- Shadow registers are internal and never visible on y.

## Timing
- Beat accepted at the clk edge where din_valid=1.
- Commit latency: y0..y3 and frame_valid change at the edge that accepts the slot-3 beat, so they are visible in the following cycle. The output-visible latency is 1 cycle after the last beat.
- frame_valid, sync_err and par_err are high for exactly one cycle per event; back-to-back events give back-to-back pulses.
- Maximum throughput: one beat per cycle, which is one frame per 4 cycles. frame_valid may pulse every 4th cycle.
- locked rises in the cycle after the first accepted SOF beat and falls in the cycle after a slot-0 missing-SOF error.

## Configuration
Macro TDM_DEMUX_PARITY_EN.

Defined:
- din_par and par_err ports exist. Each accepted beat is checked; a mismatch sets an internal frame_bad flag.
- On commit with frame_bad=1: y0..y3 are not updated, frame_valid stays 0, and par_err pulses instead. The slot-3 beat's own parity is included in the check.
- frame_bad clears at commit, at any SOF beat and at reset.
- A parity error does not affect lock state.

Undefined:
- No din_par or par_err ports and no parity logic; every complete frame commits.

## Test plan
- Reset, then beats SOF+0x1, 0x2, 0x3, 0x4 on consecutive cycles (W=4) -> frame_valid=1 for one cycle after the 4th beat; y0..y3=1,2,3,4; locked=1.
- In HUNT, beats 0xA, 0xB without SOF, then SOF+0x5, 0x6, 0x7, 0x8 -> no sync_err for the 0xA/0xB beats; a single frame with y=5,6,7,8.
- Locked; SOF+0x1, 0x2, then SOF+0x9, 0xA, 0xB, 0xC -> sync_err pulse on the second SOF; no commit of 1,2; next frame y=9,A,B,C.
- Locked after a frame; next beat 0x3 with din_sof=0 -> sync_err pulse; locked=0; y unchanged.
- Frame with 2 idle cycles between each beat, followed by rst_n=0 for one cycle after slot 1 of the next frame -> first frame commits correctly; after reset y=0, locked=0, and the partial frame is lost.
- (PARITY_EN) Frame 1,2,3,4 with a wrong din_par on slot 2 -> par_err pulse; frame_valid stays 0; y holds its previous values; next good frame commits normally.

Source files
------------

// File: rtl/tdm_demux_4.sv
// Four-lane TDM demultiplexer: locks to SOF, buffers slots 0..2, commits all four lanes at slot 3.
// Optional beat parity checking is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux_4 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         din_sof,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic         din_par,
  output logic         par_err,
`endif
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         frame_valid,
  output logic         sync_err,
  output logic         locked
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e         state_q, state_d;
  logic [1:0]     slot_q, slot_d;
  logic [W-1:0]   sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [W-1:0]   y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic           fv_q, fv_d, se_q, se_d;
  logic           frame_bad_q, frame_bad_d;
  logic           pe_q, pe_d;
  logic           beat_bad;

`ifdef TDM_DEMUX_PARITY_EN
  // Even parity: din together with din_par must have an even number of ones.
  assign beat_bad = (^din) ^ din_par;
  assign par_err  = pe_q;
`else
  assign beat_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    y3_d        = y3_q;
    frame_bad_d = frame_bad_q;
    fv_d        = 1'b0;
    se_d        = 1'b0;
    pe_d        = 1'b0;
    if (din_valid) begin
      if (din_sof) begin
        // Any SOF starts a fresh frame; mid-frame SOF is a resync error.
        if (state_q == StLocked && slot_q != 2'd0) se_d = 1'b1;
        state_d     = StLocked;
        sh0_d       = din;
        slot_d      = 2'd1;
        frame_bad_d = beat_bad;
      end else if (state_q == StLocked) begin
        unique case (slot_q)
          2'd0: begin
            se_d    = 1'b1;
            state_d = StHunt;
          end
          2'd1: begin
            sh1_d       = din;
            slot_d      = 2'd2;
            frame_bad_d = frame_bad_q | beat_bad;
          end
          2'd2: begin
            sh2_d       = din;
            slot_d      = 2'd3;
            frame_bad_d = frame_bad_q | beat_bad;
          end
          2'd3: begin
            if (frame_bad_q | beat_bad) begin
              pe_d = 1'b1;
            end else begin
              y0_d = sh0_q;
              y1_d = sh1_q;
              y2_d = sh2_q;
              y3_d = din;
              fv_d = 1'b1;
            end
            slot_d      = 2'd0;
            frame_bad_d = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      slot_q      <= 2'd0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      y3_q        <= '0;
      fv_q        <= 1'b0;
      se_q        <= 1'b0;
      pe_q        <= 1'b0;
      frame_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      y3_q        <= y3_d;
      fv_q        <= fv_d;
      se_q        <= se_d;
      pe_q        <= pe_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = (state_q == StLocked);

  // Parity state is unused when the check is compiled out.
  logic unused_par;
  assign unused_par = pe_q ^ beat_bad;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Self-checking bench for tdm_demux_4: directed frames plus random beats against a
// queue-based frame model.
module tb_tdm_demux_4;
  localparam int unsigned W = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid, din_sof;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid, sync_err, locked;
`ifdef TDM_DEMUX_PARITY_EN
  logic         din_par, par_err;
`endif

  tdm_demux_4 #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_sof    (din_sof),
`ifdef TDM_DEMUX_PARITY_EN
    .din_par    (din_par),
    .par_err    (par_err),
`endif
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .frame_valid(frame_valid),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: lock flag, beats collected for the frame in progress, last committed lanes.
  bit           m_lock;
  logic [W-1:0] part[$];
  bit           m_pbad;
  logic [W-1:0] m_y[4];
  bit           e_fv, e_se, e_pe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("y0", 32'(y0), 32'(m_y[0]));
    chk("y1", 32'(y1), 32'(m_y[1]));
    chk("y2", 32'(y2), 32'(m_y[2]));
    chk("y3", 32'(y3), 32'(m_y[3]));
    chk("frame_valid", 32'(frame_valid), 32'(e_fv));
    chk("sync_err", 32'(sync_err), 32'(e_se));
    chk("locked", 32'(locked), 32'(m_lock));
`ifdef TDM_DEMUX_PARITY_EN
    chk("par_err", 32'(par_err), 32'(e_pe));
`endif
  endtask

  task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit pbad);
    din_valid = v;
    din_sof   = s;
    din       = d;
`ifdef TDM_DEMUX_PARITY_EN
    din_par   = (^d) ^ pbad;
`endif
    @(posedge clk);
    #1;
    e_fv = 1'b0;
    e_se = 1'b0;
    e_pe = 1'b0;
    if (v) begin
      if (s) begin
        if (m_lock && part.size() != 0) e_se = 1'b1;
        m_lock = 1'b1;
        part.delete();
        part.push_back(d);
        m_pbad = pbad;
      end else if (m_lock) begin
        if (part.size() == 0) begin
          e_se   = 1'b1;
          m_lock = 1'b0;
        end else begin
          part.push_back(d);
          m_pbad = m_pbad | pbad;
          if (part.size() == 4) begin
            if (Par && m_pbad) begin
              e_pe = 1'b1;
            end else begin
              for (int i = 0; i < 4; i++) m_y[i] = part[i];
              e_fv = 1'b1;
            end
            part.delete();
          end
        end
      end
    end
    check_all();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din_sof   = 1'b0;
    din       = '0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_lock = 1'b0;
    m_pbad = 1'b0;
    part.delete();
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    e_fv = 1'b0;
    e_se = 1'b0;
    e_pe = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
`ifdef TDM_DEMUX_PARITY_EN
    din_par = 1'b0;
`endif
    rst_n = 1'b0;
    @(posedge clk);
    do_reset();

    // Basic frame 1,2,3,4.
    step(1, 1, 4'h1, 0); step(1, 0, 4'h2, 0); step(1, 0, 4'h3, 0); step(1, 0, 4'h4, 0);
    idle(1);

    // Hunt drops non-SOF beats silently.
    do_reset();
    step(1, 0, 4'hA, 0); step(1, 0, 4'hB, 0);
    step(1, 1, 4'h5, 0); step(1, 0, 4'h6, 0); step(1, 0, 4'h7, 0); step(1, 0, 4'h8, 0);

    // Mid-frame SOF resyncs.
    step(1, 1, 4'h1, 0); step(1, 0, 4'h2, 0);
    step(1, 1, 4'h9, 0); step(1, 0, 4'hA, 0); step(1, 0, 4'hB, 0); step(1, 0, 4'hC, 0);

    // Missing SOF at slot 0 drops lock.
    step(1, 0, 4'h3, 0);
    idle(1);

    // Idle gaps between beats, then reset after slot 1 of the next frame.
    step(1, 1, 4'hD, 0); idle(2); step(1, 0, 4'hE, 0); idle(2);
    step(1, 0, 4'hF, 0); idle(2); step(1, 0, 4'h0, 0); idle(2);
    step(1, 1, 4'h6, 0); step(1, 0, 4'h7, 0);
    do_reset();
    step(1, 0, 4'h8, 0); step(1, 0, 4'h9, 0);

    // Parity error on slot 2 drops the frame (commits normally without the feature).
    step(1, 1, 4'h1, 0); step(1, 0, 4'h2, 0); step(1, 0, 4'h3, 0); step(1, 0, 4'h4, 0);
    step(1, 1, 4'h1, 0); step(1, 0, 4'h2, 0); step(1, 0, 4'h3, 1); step(1, 0, 4'h4, 0);
    step(1, 1, 4'h5, 0); step(1, 0, 4'h6, 0); step(1, 0, 4'h7, 0); step(1, 0, 4'h8, 0);
    // Parity error on the slot-3 beat itself.
    step(1, 1, 4'h9, 0); step(1, 0, 4'hA, 0); step(1, 0, 4'hB, 0); step(1, 0, 4'hC, 1);

    // Random beats, mostly well-formed frames with occasional glitches.
    for (int i = 0; i < 600; i++) begin
      bit v, s, pb;
      v  = ($urandom_range(0, 3) != 0);
      s  = (part.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
      pb = ($urandom_range(0, 19) == 0);
      step(v, s, W'($urandom), pb);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
